// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and address helpers for the scoreboarded register file.
package rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG = 0;
  function automatic logic addr_hit(input logic [31:0] a, input logic [31:0] b);
    return (a == b) && (a != ZERO_REG);
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits, pending count, sticky protocol error and busy outputs.
module rf_scoreboard import rf_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              rsv_busy,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              all_clear,
  output logic              err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW = ADDR_W + 1;
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic w_set, w_clr, w_wa, w_same, w_inc, w_dec, w_err;
  assign w_set  = rsv_en && addr_hit(32'(rsv_addr), 32'(rsv_addr));
  assign w_clr  = wb_en && addr_hit(32'(wb_addr), 32'(wb_addr));
  assign w_wa   = wa_en && addr_hit(32'(wa_addr), 32'(wa_addr));
  assign w_same = w_set && w_clr && (rsv_addr == wb_addr);
  assign w_inc  = w_set && !r_pend[rsv_addr];
  assign w_dec  = w_clr && r_pend[wb_addr] && !w_same;
  // A reservation landing on the register being retired is a legal back-to-back issue.
  assign w_err  = (w_clr && !r_pend[wb_addr] && !w_same) ||
                  (w_set && r_pend[rsv_addr] && !w_same) ||
                  (w_wa && r_pend[wa_addr]) ||
                  (w_wa && w_clr && (wa_addr == wb_addr));
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_clr) w_pend_nxt[wb_addr] = 1'b0;
    if (w_set) w_pend_nxt[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= r_cnt + CW'(w_inc) - CW'(w_dec);
      r_err  <= r_err || w_err;
    end
  end
  function automatic logic busy_of(input logic [ADDR_W-1:0] x);
    return r_pend[x] && !(BYPASS && w_clr && (wb_addr == x) && !(w_set && (rsv_addr == x)));
  endfunction
  assign rs_busy   = busy_of(rs);
  assign rt_busy   = busy_of(rt);
  assign rsv_busy  = busy_of(rsv_addr);
  assign pend_cnt  = r_cnt;
  assign all_clear = (r_cnt == '0);
  assign err       = r_err;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-read/two-write register file with r0 hardwired to zero,
// optional write-to-read bypass and a pending scoreboard for long-latency results.
module regfile_sb import rf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              rsv_busy,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              all_clear,
  output logic              err
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic w_wa, w_wb;
  assign w_wa = wa_en && addr_hit(32'(wa_addr), 32'(wa_addr));
  assign w_wb = wb_en && addr_hit(32'(wb_addr), 32'(wb_addr));
  // Port A is written last so it wins an A/B collision; r_mem[0] is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wb) r_mem[wb_addr] <= wb_data;
      if (w_wa) r_mem[wa_addr] <= wa_data;
    end
  end
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return (BYPASS && w_wa && (wa_addr == a)) ? wa_data :
           (BYPASS && w_wb && (wb_addr == a)) ? wb_data : r_mem[a];
  endfunction
  assign rs_data = rd(rs);
  assign rt_data = rd(rt);
  rf_scoreboard #(.ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_sb (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt),
    .wa_en(wa_en), .wa_addr(wa_addr), .wb_en(wb_en), .wb_addr(wb_addr),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .rsv_busy(rsv_busy),
    .pend_cnt(pend_cnt), .all_clear(all_clear), .err(err)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: vector-table and hand-sequence checks of regfile_sb with and without bypass.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [4:0] rs, rt, wa_addr, wb_addr, rsv_addr;
  logic [31:0] wa_data, wb_data;
  logic wa_en, wb_en, rsv_en;
  logic [31:0] rs_data, rt_data, nb_rs_data, nb_rt_data;
  logic rs_busy, rt_busy, rsv_busy, all_clear, err;
  logic nb_rs_busy, nb_rt_busy, nb_rsv_busy, nb_all_clear, nb_err;
  logic [5:0] pend_cnt, nb_pend_cnt;
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rs_data(rs_data), .rt_data(rt_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .rsv_busy(rsv_busy),
    .pend_cnt(pend_cnt), .all_clear(all_clear), .err(err));
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) nb (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rs_data(nb_rs_data), .rt_data(nb_rt_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rs_busy(nb_rs_busy), .rt_busy(nb_rt_busy), .rsv_busy(nb_rsv_busy),
    .pend_cnt(nb_pend_cnt), .all_clear(nb_all_clear), .err(nb_err));
  typedef struct {
    logic [31:0] rs, rt, nb_rs;
    logic rs_busy, rt_busy;
    logic [5:0] cnt;
    logic err;
  } exp_t;
  typedef struct {
    logic [4:0] rs, rt;
    logic wa_en; logic [4:0] wa_addr; logic [31:0] wa_data;
    logic wb_en; logic [4:0] wb_addr; logic [31:0] wb_data;
    logic rsv_en; logic [4:0] rsv_addr;
    exp_t e;
  } vec_t;
  vec_t tv[13];
  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [4:0] a_rs, a_rt,
                              input logic a_wae, input logic [4:0] a_waa, input logic [31:0] a_wad,
                              input logic a_wbe, input logic [4:0] a_wba, input logic [31:0] a_wbd,
                              input logic a_rse, input logic [4:0] a_rsa,
                              input logic [31:0] e_rs, e_rt, e_nb,
                              input logic e_rsb, e_rtb, input logic [5:0] e_cnt, input logic e_err);
    vec_t v;
    v.rs = a_rs; v.rt = a_rt;
    v.wa_en = a_wae; v.wa_addr = a_waa; v.wa_data = a_wad;
    v.wb_en = a_wbe; v.wb_addr = a_wba; v.wb_data = a_wbd;
    v.rsv_en = a_rse; v.rsv_addr = a_rsa;
    v.e.rs = e_rs; v.e.rt = e_rt; v.e.nb_rs = e_nb;
    v.e.rs_busy = e_rsb; v.e.rt_busy = e_rtb; v.e.cnt = e_cnt; v.e.err = e_err;
    return v;
  endfunction
  task automatic idle(input logic [4:0] a_rs, input logic [4:0] a_rt);
    rs = a_rs; rt = a_rt;
    wa_en = 0; wa_addr = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    rsv_en = 0; rsv_addr = 0;
  endtask
  task automatic apply(input vec_t v);
    rs = v.rs; rt = v.rt;
    wa_en = v.wa_en; wa_addr = v.wa_addr; wa_data = v.wa_data;
    wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
    rsv_en = v.rsv_en; rsv_addr = v.rsv_addr;
  endtask
  initial begin
    exp_t e;
    tv[0]  = mk(5, 0, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 32'h1234_5678, 0, 0, 0, 0);
    tv[2]  = mk(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[3]  = mk(0, 8, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    tv[4]  = mk(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tv[5]  = mk(8, 8, 0, 0, 0, 1, 8, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0, 1, 0);
    tv[6]  = mk(8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tv[7]  = mk(9, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    tv[8]  = mk(9, 9, 0, 0, 0, 1, 9, 7, 1, 9, 7, 7, 0, 1, 1, 1, 0);
    tv[9]  = mk(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 7, 1, 1, 1, 0);
    tv[10] = mk(3, 5, 1, 3, 1, 1, 3, 2, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 1, 0);
    tv[11] = mk(3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 1, 0, 0, 1, 1);
    tv[12] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1);
    idle(5, 0);
    @(negedge clk);
    chk("reset pend_cnt", 32'(pend_cnt), 0);
    chk("reset all_clear", 32'(all_clear), 1);
    chk("reset err", 32'(err), 0);
    chk("reset rs_data", rs_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      apply(tv[i]);
      exp_q.push_back(tv[i].e);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("v%0d rs_data", i), rs_data, e.rs);
      chk($sformatf("v%0d rt_data", i), rt_data, e.rt);
      chk($sformatf("v%0d nobypass rs_data", i), nb_rs_data, e.nb_rs);
      chk($sformatf("v%0d rs_busy", i), 32'(rs_busy), 32'(e.rs_busy));
      chk($sformatf("v%0d rt_busy", i), 32'(rt_busy), 32'(e.rt_busy));
      chk($sformatf("v%0d pend_cnt", i), 32'(pend_cnt), 32'(e.cnt));
      chk($sformatf("v%0d all_clear", i), 32'(all_clear), 32'(e.cnt == 0));
      chk($sformatf("v%0d err", i), 32'(err), 32'(e.err));
      @(posedge clk); #1;
    end
    // r9 is still pending from the vector table, so only its re-reservation sees busy
    for (int a = 1; a < 32; a++) begin
      idle(5'(a), 0);
      rsv_en = 1; rsv_addr = 5'(a);
      @(negedge clk);
      chk($sformatf("rsv r%0d rsv_busy", a), 32'(rsv_busy), 32'(a == 9));
      @(posedge clk); #1;
    end
    idle(9, 17);
    @(negedge clk);
    chk("full pend_cnt", 32'(pend_cnt), 31);
    chk("full all_clear", 32'(all_clear), 0);
    chk("full rt_busy", 32'(rt_busy), 1);
    chk("full err sticky", 32'(err), 1);
    @(posedge clk); #1;
    idle(5, 9);
    rsv_en = 1; rsv_addr = 5'd4;
    #3 rst = 1'b1;
    #1;
    chk("async rst pend_cnt", 32'(pend_cnt), 0);
    chk("async rst all_clear", 32'(all_clear), 1);
    chk("async rst err", 32'(err), 0);
    chk("async rst rs_data", rs_data, 0);
    chk("async rst nobypass rs_data", nb_rs_data, 0);
    chk("async rst rt_busy", 32'(rt_busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(10, 0);
    wb_en = 1; wb_addr = 5'd10; wb_data = 32'hA5A5_0F0F;
    @(negedge clk);
    chk("post-rst wb err before edge", 32'(err), 0);
    chk("post-rst wb bypass", rs_data, 32'hA5A5_0F0F);
    @(posedge clk); #1 idle(10, 0);
    @(negedge clk);
    chk("post-rst wb err", 32'(err), 1);
    chk("post-rst wb stored", rs_data, 32'hA5A5_0F0F);
    chk("post-rst wb stored nobypass", nb_rs_data, 32'hA5A5_0F0F);
    chk("post-rst pend_cnt", 32'(pend_cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
